mips_dcache: RTL and testbench
==============================

Name: mips_dcache

Overview:
- Parametrised, direct-mapped, write-back, write-allocate data cache for the MIPS core.
- Sits between the core's ALU-address/store-data path and the byte-lane data memory.
- Successor to the core's fixed cache. Adds configurable geometry and memory latency, multi-word lines, a stall handshake to the core, and a halt-time flush of dirty lines so memory is coherent when `halted` asserts.
- Also provides hit/miss performance counters.

Parameters:
- NUM_LINES, 16, number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, ≥1.
- MEM_LATENCY, 4, cycles per memory word access; ≥1.
- CNT_W, 32, width of the hit/miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  core byte address (ALU result); bits [1:0] ignored.
- wdata  in  32  core store data (register rt).
- read_en  in  1  load request.
- write_en  in  1  store request.
- rdata  out  32  load data; valid when read_en=1 and stall=0.
- stall  out  1  core must freeze PC and hold addr/wdata/read_en/write_en while high.
- flush  in  1  level request to write back all dirty lines (driven from the core's halt).
- flush_done  out  1  one-cycle pulse when a flush completes.
- mem_addr  out  32  word-aligned memory address.
- mem_data_in  out  [7:0][0:3]  write data to memory; lane 0 = bits [31:24] (big-endian).
- mem_data_out  in  [7:0][0:3]  read data from memory; same lane order.
- mem_write_en  out  1  memory write strobe.
- hit_count  out  CNT_W  saturating count of hits.
- miss_count  out  CNT_W  saturating count of misses.

Behaviour:
- Address split: [1:0] byte, then log2(WORDS_PER_LINE) word-offset bits, then log2(NUM_LINES) index bits, remainder tag. Defaults: word [3:2], index [7:4], tag [31:8].
- Reset, asynchronous:
  - all valid and dirty bits = 0; state = IDLE; counters = 0.
  - stall = 0, flush_done = 0, mem_write_en = 0, mem_addr = 0, rdata = 0.
  - Tag and data arrays are not reset.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH.
- IDLE, request present (read_en or write_en):
  - Hit (valid && tag match): stall = 0 combinationally.
  - Read hit: rdata = word combinationally (zero-latency).
  - Write hit: word updated at the edge and dirty set.
  - hit_count increments on the hit edge.
- IDLE, miss:
  - stall = 1 combinationally; miss_count increments.
  - Victim dirty → WRITEBACK, else → REFILL.
- WRITEBACK:
  - For each word w = 0..WORDS_PER_LINE-1, hold mem_addr = {victim tag, index, w, 2'b00} and mem_data_in = the victim word, with mem_write_en = 1, for MEM_LATENCY cycles.
  - Then clear dirty and go to REFILL.
- REFILL:
  - For each word, hold mem_addr = {request tag, index, w, 2'b00} for MEM_LATENCY cycles.
  - Sample mem_data_out on the last cycle of each slot.
  - After the last word: set valid and tag, go to IDLE. The retried request then hits (write-allocate).
- Stall length:
  - Clean miss: stall high 1 + WORDS_PER_LINE*MEM_LATENCY cycles (17 at defaults).
  - Dirty miss: 1 + 2*WORDS_PER_LINE*MEM_LATENCY cycles (33).
  - Stall is low in the resolving hit cycle.
- read_en and write_en both high: treated as a write.
- flush:
  - Sampled only in IDLE with no request pending; pending requests take priority.
  - FLUSH scans indices 0..NUM_LINES-1 at one cycle per clean line. Each dirty line performs the WRITEBACK sequence and has its dirty bit cleared; valid is kept.
  - After the last index, flush_done pulses for one cycle and the FSM returns to IDLE.
  - stall = 1 throughout FLUSH.
  - Flush still high after completion does not restart the scan until flush drops for ≥1 cycle.
- Counters saturate at all-ones. A hit after refill counts as a hit, so each miss also yields one hit.
- Reset mid-operation: the operation aborts immediately, unwritten dirty data is lost, and all outputs return to their reset values.
- Index and word counters wrap only via FSM exit; no modular wrap is visible outside.

Decomposition:
- Package `mips_dcache_pkg`:
  - state enum `dcache_state_t` {IDLE, WRITEBACK, REFILL, FLUSH};
  - byte-lane pack/unpack functions (32-bit ↔ [7:0][0:3], big-endian);
  - derived width functions (offset, index and tag bit widths).
- One sub-module is natural: `dcache_mem_seq`, the word/latency counter pair that sequences WRITEBACK and REFILL bursts and reports slot_last/burst_done.

Test Plan:
- Memory preloaded with 0x100→0xDEADBEEF, 0x104→0x00000001:
  - reset, then read 0x100 → stall high 17 cycles, mem_addr walks 0x100/104/108/10C at 4 cycles each, rdata = 0xDEADBEEF, miss_count = 1.
  - read 0x104 → no stall, rdata = 0x00000001, hit_count = 2.
- Write 0x100 = 0x12345678 (hit) → stall 0, no mem_write_en. Read 0x100 → 0x12345678.
- With line 0 dirty, read 0x500 (same index, tag 5) → stall 33 cycles; mem_write_en high 16 cycles at 0x100..0x10C, memory 0x100 = 0x12345678; then refill from 0x500.
- Make lines 0 and 3 dirty, assert flush → writes only at index 0 and 3 addresses; flush_done pulses once. Second flush with no dirty lines → flush_done after 16 cycles, mem_write_en never high.
- Write miss to 0x200 with 0xCAFEF00D → refill, then word written and line dirty. Memory 0x200 is unchanged until eviction or flush.
- Assert reset on cycle 5 of a refill → stall = 0 and mem_write_en = 0 immediately. Re-reading the same address misses again (miss_count = 1 after reset).

Source files
------------

// File: rtl/mips_dcache_pkg.sv
// Shared types and helpers for the parametrised MIPS data cache.
package mips_dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, FLUSH} dcache_state_t;

    // Memory word as four byte lanes; lane 0 holds bits [31:24] (big-endian).
    typedef logic [0:3][7:0] lanes_t;

    // Number of word-offset bits inside a line.
    function automatic int unsigned offset_w(int unsigned words);
        return (words > 1) ? $clog2(words) : 0;
    endfunction

    // Number of index bits.
    function automatic int unsigned index_w(int unsigned lines);
        return $clog2(lines);
    endfunction

    // Number of tag bits left above byte, word and index fields.
    function automatic int unsigned tag_w(int unsigned lines, int unsigned words);
        return 30 - offset_w(words) - index_w(lines);
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic lanes_t pack_word(logic [31:0] w);
        lanes_t l;
        for (int i = 0; i < 4; i++) begin
            l[i] = w[31-8*i -: 8];
        end
        return l;
    endfunction

    function automatic logic [31:0] unpack_lanes(lanes_t l);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[31-8*i -: 8] = l[i];
        end
        return w;
    endfunction

endpackage

// File: rtl/mips_dcache_if.sv
// Core request / memory bus bundle for the data cache.
interface mips_dcache_if
    import mips_dcache_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) ();
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             read_en;
    logic             write_en;
    logic [31:0]      rdata;
    logic             stall;
    logic             flush;
    logic             flush_done;
    logic [31:0]      mem_addr;
    lanes_t           mem_data_in;
    lanes_t           mem_data_out;
    logic             mem_write_en;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    // Cache side.
    modport slave (
        input  addr, wdata, read_en, write_en, flush, mem_data_out,
        output rdata, stall, flush_done, mem_addr, mem_data_in, mem_write_en,
        output hit_count, miss_count
    );

    // Core plus memory side.
    modport master (
        output addr, wdata, read_en, write_en, flush, mem_data_out,
        input  rdata, stall, flush_done, mem_addr, mem_data_in, mem_write_en,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/dcache_mem_seq.sv
// Word/latency counter pair that paces writeback and refill bursts.
module dcache_mem_seq
    import mips_dcache_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned MEM_LATENCY    = 4,
    localparam int unsigned WW = cnt_w(WORDS_PER_LINE),
    localparam int unsigned LW = cnt_w(MEM_LATENCY)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [WW-1:0] word,
    output logic          slot_last,
    output logic          burst_done
);
    logic [LW-1:0] lat_q;
    logic [WW-1:0] word_q;

    // Decode the last cycle of a word slot and of the whole burst.
    always_comb begin
        slot_last  = (lat_q == LW'(MEM_LATENCY - 1));
        burst_done = slot_last && (word_q == WW'(WORDS_PER_LINE - 1));
    end

    assign word = word_q;

    // Counters rest at zero and return there at the end of every burst, so
    // a writeback can chain straight into a refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_q  <= '0;
            word_q <= '0;
        end else if (!run || burst_done) begin
            lat_q  <= '0;
            word_q <= '0;
        end else if (slot_last) begin
            lat_q  <= '0;
            word_q <= word_q + 1'b1;
        end else begin
            lat_q  <= lat_q + 1'b1;
        end
    end
endmodule

// File: rtl/mips_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with halt-time flush.
module mips_dcache
    import mips_dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned MEM_LATENCY    = 4,
    parameter int unsigned CNT_W          = 32
) (
    input logic          clk,
    input logic          reset,
    mips_dcache_if.slave bus
);
    localparam int unsigned OW = offset_w(WORDS_PER_LINE);
    localparam int unsigned IW = index_w(NUM_LINES);
    localparam int unsigned TW = tag_w(NUM_LINES, WORDS_PER_LINE);
    localparam int unsigned WW = cnt_w(WORDS_PER_LINE);

    dcache_state_t        state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TW-1:0]        tag_arr [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];
    logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;
    logic                 in_flush_q, flush_armed_q;
    logic [IW-1:0]        flush_idx_q;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx, line_idx;
    logic [WW-1:0] req_word, seq_word;
    logic          req, hit, seq_run, slot_last, burst_done;
    logic          stall, mem_write_en;
    logic          do_hit, do_miss, wr_hit, fill_word, fill_done, wb_done;
    logic          flush_start, flush_step;

    function automatic logic [31:0] line_addr(logic [TW-1:0] t, logic [IW-1:0] i,
                                              logic [WW-1:0] w);
        return (32'(t) << (2 + OW + IW)) | (32'(i) << (2 + OW)) | (32'(w) << 2);
    endfunction

    dcache_mem_seq #(
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .MEM_LATENCY    (MEM_LATENCY)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .run        (seq_run),
        .word       (seq_word),
        .slot_last  (slot_last),
        .burst_done (burst_done)
    );

    // Address split and hit detection; flush bursts use the scan index.
    always_comb begin
        req_word = WW'((bus.addr >> 2) & 32'(WORDS_PER_LINE - 1));
        req_idx  = IW'(bus.addr >> (2 + OW));
        req_tag  = TW'(bus.addr >> (2 + OW + IW));
        line_idx = in_flush_q ? flush_idx_q : req_idx;
        req      = bus.read_en | bus.write_en;
        hit      = valid_q[req_idx] && (tag_arr[req_idx] == req_tag);
        seq_run  = (state_q == WRITEBACK) || (state_q == REFILL);
    end

    // Next state, core/memory outputs and update strobes.
    always_comb begin
        state_d         = state_q;
        stall           = 1'b0;
        bus.rdata       = '0;
        bus.mem_addr    = '0;
        bus.mem_data_in = '0;
        mem_write_en    = 1'b0;
        bus.flush_done  = 1'b0;
        do_hit          = 1'b0;
        do_miss         = 1'b0;
        wr_hit          = 1'b0;
        fill_word       = 1'b0;
        fill_done       = 1'b0;
        wb_done         = 1'b0;
        flush_start     = 1'b0;
        flush_step      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        do_hit = 1'b1;
                        wr_hit = bus.write_en;
                        if (!bus.write_en) bus.rdata = data_arr[req_idx][req_word];
                    end else begin
                        stall   = 1'b1;
                        do_miss = 1'b1;
                        state_d = dirty_q[req_idx] ? WRITEBACK : REFILL;
                    end
                end else if (bus.flush && flush_armed_q) begin
                    flush_start = 1'b1;
                    state_d     = FLUSH;
                end
            end
            WRITEBACK: begin
                stall           = 1'b1;
                mem_write_en    = 1'b1;
                bus.mem_addr    = line_addr(tag_arr[line_idx], line_idx, seq_word);
                bus.mem_data_in = pack_word(data_arr[line_idx][seq_word]);
                if (burst_done) begin
                    wb_done = 1'b1;
                    state_d = in_flush_q ? FLUSH : REFILL;
                end
            end
            REFILL: begin
                stall        = 1'b1;
                bus.mem_addr = line_addr(req_tag, req_idx, seq_word);
                fill_word    = slot_last;
                if (burst_done) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            FLUSH: begin
                stall = 1'b1;
                if (dirty_q[flush_idx_q]) begin
                    state_d = WRITEBACK;
                end else begin
                    flush_step = 1'b1;
                    if (flush_idx_q == IW'(NUM_LINES - 1)) begin
                        bus.flush_done = 1'b1;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset forces the handshake outputs low immediately, even mid-burst.
    assign bus.stall        = stall & ~reset;
    assign bus.mem_write_en = mem_write_en & ~reset;
    assign bus.hit_count    = hit_cnt_q;
    assign bus.miss_count   = miss_cnt_q;

    // Control state: FSM, line status bits, counters and flush scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            in_flush_q    <= 1'b0;
            flush_armed_q <= 1'b1;
            flush_idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (do_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            if (do_miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (wr_hit) dirty_q[req_idx] <= 1'b1;
            if (wb_done) dirty_q[line_idx] <= 1'b0;
            if (fill_done) valid_q[req_idx] <= 1'b1;
            // A held flush level must drop before another scan can start.
            if (flush_start) begin
                in_flush_q    <= 1'b1;
                flush_idx_q   <= '0;
                flush_armed_q <= 1'b0;
            end else if (!bus.flush) begin
                flush_armed_q <= 1'b1;
            end
            if (flush_step) begin
                if (flush_idx_q == IW'(NUM_LINES - 1)) in_flush_q <= 1'b0;
                else flush_idx_q <= flush_idx_q + 1'b1;
            end
        end
    end

    // Tag and data storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (fill_done) tag_arr[req_idx] <= req_tag;
        if (fill_word) data_arr[req_idx][seq_word] <= unpack_lanes(bus.mem_data_out);
        if (wr_hit) data_arr[req_idx][req_word] <= bus.wdata;
    end
endmodule

// File: tb/tb_mips_dcache.sv
// Directed self-checking bench for mips_dcache at default geometry.
module tb_mips_dcache;
    import mips_dcache_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem [1024];
    logic [31:0] addr_log [64];
    logic [31:0] first_wr, last_wr;

    mips_dcache_if #(.CNT_W(32)) bus ();

    mips_dcache dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_data_out = pack_word(mem[bus.mem_addr[11:2]]);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory writes are applied when sampled; write data is held for the whole slot.
    task automatic mem_sample(inout int wrs);
        if (bus.mem_write_en) begin
            if (wrs == 0) first_wr = bus.mem_addr;
            last_wr = bus.mem_addr;
            wrs++;
            mem[bus.mem_addr[11:2]] = unpack_lanes(bus.mem_data_in);
        end
    endtask

    // Issue one request from a negedge, hold it through the stall, return at a negedge.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output int wrs,
                          output logic [31:0] rd_val);
        bus.addr = a; bus.wdata = d; bus.read_en = rd; bus.write_en = wr;
        stalls = 0; wrs = 0;
        #1;
        while (bus.stall && stalls < 200) begin
            if (stalls < 64) addr_log[stalls] = bus.mem_addr;
            mem_sample(wrs);
            stalls++;
            @(negedge clk); #1;
        end
        rd_val = bus.rdata;
        @(negedge clk);
        bus.read_en = 1'b0; bus.write_en = 1'b0;
    endtask

    task automatic do_flush(output int done_at, output int wrs, output int mask,
                            output int pulses);
        bus.flush = 1'b1;
        done_at = -1; wrs = 0; mask = 0; pulses = 0;
        #1;
        for (int k = 0; k < 300 && done_at < 0; k++) begin
            if (bus.mem_write_en) mask |= 1 << ((bus.mem_addr >> 4) & 15);
            mem_sample(wrs);
            if (bus.flush_done) begin done_at = k; pulses++; end
            @(negedge clk); #1;
        end
        // Flush stays high: no second scan may start.
        for (int k = 0; k < 5; k++) begin
            if (bus.flush_done) pulses++;
            mem_sample(wrs);
            @(negedge clk); #1;
        end
        bus.flush = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, wr, done_at, mask, pulses;
        logic [31:0] rv;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'hDEADBEEF;
        mem[32'h104 >> 2] = 32'h0000_0001;
        mem[32'h500 >> 2] = 32'h5555_0000;
        mem[32'h200 >> 2] = 32'h1111_2222;
        mem[32'h700 >> 2] = 32'h7700_7700;
        reset = 1'b1;
        bus.addr = '0; bus.wdata = '0; bus.read_en = 1'b0; bus.write_en = 1'b0;
        bus.flush = 1'b0;
        #1;
        check_eq("rst_stall", 32'(bus.stall), 32'd0);
        check_eq("rst_mwe", 32'(bus.mem_write_en), 32'd0);
        check_eq("rst_maddr", bus.mem_addr, 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_done", 32'(bus.flush_done), 32'd0);
        check_eq("rst_hits", bus.hit_count, 32'd0);
        @(negedge clk); reset = 1'b0; @(negedge clk);

        // Clean miss.
        do_req(1'b1, 1'b0, 32'h100, 32'h0, st, wr, rv);
        check_eq("miss_stall", 32'(st), 32'd17);
        check_eq("walk0", addr_log[1], 32'h100);
        check_eq("walk1", addr_log[5], 32'h104);
        check_eq("walk2", addr_log[9], 32'h108);
        check_eq("walk3", addr_log[13], 32'h10C);
        check_eq("miss_rdata", rv, 32'hDEADBEEF);
        check_eq("miss_cnt1", bus.miss_count, 32'd1);

        do_req(1'b1, 1'b0, 32'h104, 32'h0, st, wr, rv);
        check_eq("hit_stall", 32'(st), 32'd0);
        check_eq("hit_rdata", rv, 32'h0000_0001);
        check_eq("hit_cnt2", bus.hit_count, 32'd2);

        do_req(1'b0, 1'b1, 32'h100, 32'h1234_5678, st, wr, rv);
        check_eq("whit_stall", 32'(st), 32'd0);
        check_eq("whit_nowr", 32'(wr), 32'd0);
        do_req(1'b1, 1'b0, 32'h100, 32'h0, st, wr, rv);
        check_eq("whit_rd", rv, 32'h1234_5678);

        // Dirty miss on the same index.
        do_req(1'b1, 1'b0, 32'h500, 32'h0, st, wr, rv);
        check_eq("dmiss_stall", 32'(st), 32'd33);
        check_eq("dmiss_wrs", 32'(wr), 32'd16);
        check_eq("dmiss_first", first_wr, 32'h100);
        check_eq("dmiss_last", last_wr, 32'h10C);
        check_eq("dmiss_mem100", mem[32'h100 >> 2], 32'h1234_5678);
        check_eq("dmiss_mem104", mem[32'h104 >> 2], 32'h0000_0001);
        check_eq("dmiss_rdata", rv, 32'h5555_0000);
        check_eq("dmiss_cnt", bus.miss_count, 32'd2);

        // Write miss allocates and stays in the cache.
        do_req(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, st, wr, rv);
        check_eq("wmiss_stall", 32'(st), 32'd17);
        check_eq("wmiss_mem", mem[32'h200 >> 2], 32'h1111_2222);
        do_req(1'b1, 1'b0, 32'h200, 32'h0, st, wr, rv);
        check_eq("wmiss_rd", rv, 32'hCAFE_F00D);
        do_req(1'b0, 1'b1, 32'h030, 32'hA5A5_A5A5, st, wr, rv);
        check_eq("hits_tot", bus.hit_count, 32'd8);
        check_eq("miss_tot", bus.miss_count, 32'd4);

        // Flush with lines 0 and 3 dirty.
        do_flush(done_at, wr, mask, pulses);
        check_eq("fl_done_at", 32'(done_at), 32'd50);
        check_eq("fl_wrs", 32'(wr), 32'd32);
        check_eq("fl_mask", 32'(mask), 32'h9);
        check_eq("fl_pulses", 32'(pulses), 32'd1);
        check_eq("fl_mem200", mem[32'h200 >> 2], 32'hCAFE_F00D);
        check_eq("fl_mem030", mem[32'h030 >> 2], 32'hA5A5_A5A5);

        do_flush(done_at, wr, mask, pulses);
        check_eq("fl2_done_at", 32'(done_at), 32'd16);
        check_eq("fl2_wrs", 32'(wr), 32'd0);
        check_eq("fl2_pulses", 32'(pulses), 32'd1);

        // Reset in the middle of a refill.
        bus.addr = 32'h700; bus.read_en = 1'b1;
        #1;
        check_eq("mr_stall", 32'(bus.stall), 32'd1);
        repeat (5) begin @(negedge clk); #1; end
        check_eq("mr_addr", bus.mem_addr, 32'h704);
        reset = 1'b1;
        #1;
        check_eq("mr_rst_stall", 32'(bus.stall), 32'd0);
        check_eq("mr_rst_mwe", 32'(bus.mem_write_en), 32'd0);
        check_eq("mr_rst_maddr", bus.mem_addr, 32'h0);
        check_eq("mr_rst_miss", bus.miss_count, 32'd0);
        @(negedge clk); reset = 1'b0; bus.read_en = 1'b0; @(negedge clk);
        do_req(1'b1, 1'b0, 32'h700, 32'h0, st, wr, rv);
        check_eq("mr_restall", 32'(st), 32'd17);
        check_eq("mr_rdata", rv, 32'h7700_7700);
        check_eq("mr_miss1", bus.miss_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
